universal_ff_bank: RTL and testbench

//  Parametrised bank of WIDTH flip-flops with a runtime-selectable mode: SR, JK, D or T.

---
 rtl/ff_bank_pkg.sv | 11 +
 rtl/ff_next_cell.sv | 40 ++++
 rtl/universal_ff_bank.sv | 88 ++++++++
 tb/tb_universal_ff_bank.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// Shared mode encodings for the universal flip-flop bank.
package ff_bank_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SR = 2'b00;
    localparam mode_t MODE_JK = 2'b01;
    localparam mode_t MODE_D  = 2'b10;
    localparam mode_t MODE_T  = 2'b11;

endpackage

// File: rtl/ff_next_cell.sv
// One channel of the bank: combinational next state and illegal-input flag.
module ff_next_cell
    import ff_bank_pkg::*;
(
    input  mode_t mode,
    input  logic  a,
    input  logic  b,
    input  logic  q,
    output logic  q_next,
    output logic  illegal
);

    always_comb begin
        q_next  = q;
        illegal = 1'b0;
        case (mode)
            MODE_SR: begin
                // S=1,R=1 is forbidden: keep q and report it
                case ({a, b})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   illegal = 1'b1;
                    default: q_next = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_D:  q_next = a;
            MODE_T:  q_next = a ? ~q : q;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/universal_ff_bank.sv
// WIDTH-channel flip-flop bank with runtime SR/JK/D/T mode, sticky illegal-input
// flags and a saturating count of individual q bit transitions.
module universal_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode_ld,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] err_sticky,
    output logic [CNT_W-1:0] flip_cnt
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_r;
    mode_t            mode_r;
    logic [WIDTH-1:0] err_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] illegal;
    logic [WIDTH-1:0] diff;
    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_next_cell u_cell (
            .mode    (mode_r),
            .a       (a[i]),
            .b       (b[i]),
            .q       (q_r[i]),
            .q_next  (q_next[i]),
            .illegal (illegal[i])
        );
    end

    // Sum is formed one bit wider than either operand so saturation is exact.
    always_comb begin
        diff = q_next ^ q_r;
        pc   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + PC_W'(diff[i]);
        end
        sum      = SUM_W'(cnt_r) + SUM_W'(pc);
        cnt_next = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r    <= RESET_VAL;
            mode_r <= MODE_SR;
            err_r  <= '0;
            cnt_r  <= '0;
        end else begin
            if (mode_ld) begin
                mode_r <= mode_in;
            end
            // A fresh illegal input on the same edge beats the clear
            err_r <= (clr_err ? '0 : err_r) | (en ? illegal : '0);
            if (en) begin
                q_r   <= q_next;
                cnt_r <= cnt_next;
            end
        end
    end

    assign q          = q_r;
    assign qbar       = ~q_r;
    assign mode       = mode_r;
    assign err_sticky = err_r;
    assign flip_cnt   = cnt_r;

endmodule

// File: tb/tb_universal_ff_bank.sv
// Directed bench: driver pushes hand-computed expectations, negedge monitor pops and compares.
module tb_universal_ff_bank;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] qbar;
        logic [1:0] mode;
        logic [7:0] err;
        logic [7:0] cnt;
        logic [7:0] q4;
        logic [7:0] qbar4;
        logic [1:0] mode4;
        logic [7:0] err4;
        logic [3:0] cnt4;
    } obs_t;

    localparam int OBS_W = $bits(obs_t);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reset4 = 1'b1;
    logic       en = 1'b0;
    logic       mode_ld = 1'b0;
    logic [1:0] mode_in = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       clr_err = 1'b0;

    logic [7:0] q, qbar, err_sticky, flip_cnt;
    logic [1:0] mode;
    logic [7:0] q4, qbar4, err4;
    logic [1:0] mode4;
    logic [3:0] cnt4;

    logic [OBS_W-1:0] exp_q[$];
    string            name_q[$];
    int               n_checks = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    universal_ff_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(8'hA5)) dut (
        .clk(clk), .reset(reset), .en(en), .mode_ld(mode_ld), .mode_in(mode_in),
        .a(a), .b(b), .clr_err(clr_err), .q(q), .qbar(qbar), .mode(mode),
        .err_sticky(err_sticky), .flip_cnt(flip_cnt)
    );

    universal_ff_bank #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut4 (
        .clk(clk), .reset(reset4), .en(en), .mode_ld(mode_ld), .mode_in(mode_in),
        .a(a), .b(b), .clr_err(clr_err), .q(q4), .qbar(qbar4), .mode(mode4),
        .err_sticky(err4), .flip_cnt(cnt4)
    );

    function automatic obs_t mk(input logic [7:0] eq, input logic [1:0] em,
                                input logic [7:0] ee, input logic [7:0] ec,
                                input logic [7:0] eq4, input logic [1:0] em4,
                                input logic [3:0] ec4);
        obs_t o;
        o.q = eq;   o.qbar = ~eq;   o.mode = em;   o.err = ee;  o.cnt = ec;
        o.q4 = eq4; o.qbar4 = ~eq4; o.mode4 = em4; o.err4 = 8'h00; o.cnt4 = ec4;
        return o;
    endfunction

    // Drive one edge's inputs, then queue the state expected after that edge.
    task automatic step(input string nm, input logic rst, input logic rst4,
                        input logic e, input logic ld, input logic [1:0] mi,
                        input logic [7:0] ai, input logic [7:0] bi, input logic clr,
                        input obs_t exp_o);
        reset = rst; reset4 = rst4; en = e; mode_ld = ld; mode_in = mi;
        a = ai; b = bi; clr_err = clr;
        @(posedge clk);
        #1;
        exp_q.push_back(exp_o);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  act;
            obs_t  ex;
            string nm;
            ex = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {q, qbar, mode, err_sticky, flip_cnt, q4, qbar4, mode4, err4, cnt4};
            n_checks++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL %s: got q=%h qbar=%h mode=%0d err=%h cnt=%0d | q4=%h qbar4=%h mode4=%0d err4=%h cnt4=%0d ; want q=%h qbar=%h mode=%0d err=%h cnt=%0d | q4=%h qbar4=%h mode4=%0d err4=%h cnt4=%0d",
                         nm, act.q, act.qbar, act.mode, act.err, act.cnt,
                         act.q4, act.qbar4, act.mode4, act.err4, act.cnt4,
                         ex.q, ex.qbar, ex.mode, ex.err, ex.cnt,
                         ex.q4, ex.qbar4, ex.mode4, ex.err4, ex.cnt4);
            end
        end
    end

    initial begin
        // reset
        step("reset_1", 1, 1, 0, 0, 2'd0, 8'h00, 8'h00, 0, mk(8'hA5, 0, 8'h00, 0, 8'h00, 0, 0));
        step("reset_2", 1, 1, 0, 0, 2'd0, 8'h00, 8'h00, 0, mk(8'hA5, 0, 8'h00, 0, 8'h00, 0, 0));
        // SR mode
        step("sr_clear", 0, 1, 1, 0, 2'd0, 8'h00, 8'hFF, 0, mk(8'h00, 0, 8'h00, 4, 8'h00, 0, 0));
        step("sr_set_0f", 0, 1, 1, 0, 2'd0, 8'h0F, 8'hF0, 0, mk(8'h0F, 0, 8'h00, 8, 8'h00, 0, 0));
        step("sr_illegal", 0, 1, 1, 0, 2'd0, 8'hFF, 8'hFF, 0, mk(8'h0F, 0, 8'hFF, 8, 8'h00, 0, 0));
        // JK mode, loaded while disabled
        step("jk_load_en0", 0, 1, 0, 1, 2'd1, 8'hFF, 8'hFF, 0, mk(8'h0F, 1, 8'hFF, 8, 8'h00, 0, 0));
        step("jk_reset_q", 0, 1, 1, 0, 2'd0, 8'h00, 8'hFF, 0, mk(8'h00, 1, 8'hFF, 12, 8'h00, 0, 0));
        step("jk_toggle_1", 0, 1, 1, 0, 2'd0, 8'hFF, 8'hFF, 0, mk(8'hFF, 1, 8'hFF, 20, 8'h00, 0, 0));
        step("jk_toggle_2", 0, 1, 1, 0, 2'd0, 8'hFF, 8'hFF, 0, mk(8'h00, 1, 8'hFF, 28, 8'h00, 0, 0));
        step("jk_toggle_3", 0, 1, 1, 0, 2'd0, 8'hFF, 8'hFF, 0, mk(8'hFF, 1, 8'hFF, 36, 8'h00, 0, 0));
        // D mode loaded on an enabled edge: that edge is still JK (00 holds)
        step("d_load_old_mode", 0, 1, 1, 1, 2'd2, 8'h00, 8'h00, 0, mk(8'hFF, 2, 8'hFF, 36, 8'h00, 0, 0));
        step("d_capture_3c", 0, 1, 1, 0, 2'd0, 8'h3C, 8'h00, 0, mk(8'h3C, 2, 8'hFF, 40, 8'h00, 0, 0));
        // clr_err racing a new SR error
        step("sr_load_en0", 0, 1, 0, 1, 2'd0, 8'h00, 8'h00, 0, mk(8'h3C, 0, 8'hFF, 40, 8'h00, 0, 0));
        step("clr_vs_new_err", 0, 1, 1, 0, 2'd0, 8'h01, 8'h01, 1, mk(8'h3C, 0, 8'h01, 40, 8'h00, 0, 0));
        step("clr_en0", 0, 1, 0, 0, 2'd0, 8'h01, 8'h01, 1, mk(8'h3C, 0, 8'h00, 40, 8'h00, 0, 0));
        // reset mid-stream discards that edge's inputs
        step("reset_midstream", 1, 1, 1, 1, 2'd3, 8'hFF, 8'h00, 0, mk(8'hA5, 0, 8'h00, 0, 8'h00, 0, 0));
        // T mode on the main bank
        step("t_load_en0", 0, 1, 0, 1, 2'd3, 8'hFF, 8'h00, 0, mk(8'hA5, 3, 8'h00, 0, 8'h00, 0, 0));
        step("t_toggle_0f", 0, 1, 1, 0, 2'd0, 8'h0F, 8'h00, 0, mk(8'hAA, 3, 8'h00, 4, 8'h00, 0, 0));
        step("en0_hold", 0, 1, 0, 0, 2'd0, 8'hFF, 8'hFF, 0, mk(8'hAA, 3, 8'h00, 4, 8'h00, 0, 0));
        // Narrow-counter bank: release its reset and load T mode
        step("cnt4_t_load", 0, 0, 0, 1, 2'd3, 8'hFF, 8'h00, 0, mk(8'hAA, 3, 8'h00, 4, 8'h00, 3, 0));
        step("cnt4_toggle_1", 0, 0, 1, 0, 2'd0, 8'hFF, 8'h00, 0, mk(8'h55, 3, 8'h00, 12, 8'hFF, 3, 8));
        step("cnt4_saturate", 0, 0, 1, 0, 2'd0, 8'hFF, 8'h00, 0, mk(8'hAA, 3, 8'h00, 20, 8'h00, 3, 15));
        step("cnt4_stay_sat", 0, 0, 1, 0, 2'd0, 8'hFF, 8'h00, 0, mk(8'h55, 3, 8'h00, 28, 8'hFF, 3, 15));
        step("cnt4_stay_sat2", 0, 0, 1, 0, 2'd0, 8'hFF, 8'h00, 0, mk(8'hAA, 3, 8'h00, 36, 8'h00, 3, 15));
        en = 1'b0; mode_ld = 1'b0; clr_err = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
